// File: rtl/hazard_ctrl_if.sv
// Hazard controller port bundle: D-stage operand needs, E/M pending writes, mult/div status.
// Purely combinational signal grouping; no latency of its own.
// No backpressure; the controller answers with hold/bubble requests instead.
// Optional HAZARD_STAT_EN adds the stallCount output.
interface hazard_ctrl_if;
  logic [4:0]  rsD;
  logic [4:0]  rtD;
  logic [1:0]  TuseRsD;
  logic [1:0]  TuseRtD;
  logic        RegWriteE;
  logic [4:0]  A3E;
  logic [1:0]  TnewE;
  logic        RegWriteM;
  logic [4:0]  A3M;
  logic [1:0]  TnewM;
  logic        mdStartE;
  logic        mdTypeE;
  logic        mdUseD;
  logic        stallPC;
  logic        stallFD;
  logic        clrDE;
  logic [1:0]  fwdRsD;
  logic [1:0]  fwdRtD;
  logic        mdBusy;
`ifdef HAZARD_STAT_EN
  logic [31:0] stallCount;
`endif

  // Pipeline side: drives the stage information, observes the controls.
`ifdef HAZARD_STAT_EN
  modport master (
    output rsD, rtD, TuseRsD, TuseRtD, RegWriteE, A3E, TnewE,
           RegWriteM, A3M, TnewM, mdStartE, mdTypeE, mdUseD,
    input  stallPC, stallFD, clrDE, fwdRsD, fwdRtD, mdBusy, stallCount
  );
`else
  modport master (
    output rsD, rtD, TuseRsD, TuseRtD, RegWriteE, A3E, TnewE,
           RegWriteM, A3M, TnewM, mdStartE, mdTypeE, mdUseD,
    input  stallPC, stallFD, clrDE, fwdRsD, fwdRtD, mdBusy
  );
`endif

  // Controller side.
`ifdef HAZARD_STAT_EN
  modport slave (
    input  rsD, rtD, TuseRsD, TuseRtD, RegWriteE, A3E, TnewE,
           RegWriteM, A3M, TnewM, mdStartE, mdTypeE, mdUseD,
    output stallPC, stallFD, clrDE, fwdRsD, fwdRtD, mdBusy, stallCount
  );
`else
  modport slave (
    input  rsD, rtD, TuseRsD, TuseRtD, RegWriteE, A3E, TnewE,
           RegWriteM, A3M, TnewM, mdStartE, mdTypeE, mdUseD,
    output stallPC, stallFD, clrDE, fwdRsD, fwdRtD, mdBusy
  );
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// D-stage hazard/stall controller with mult/div busy counter for the 5-stage MIPS pipeline.
// Stall and forward selects are combinational (zero latency); only mdCnt/stallCount are registered.
// No backpressure input; a single stall bit holds PC and F/D and bubbles D/E.
// Optional HAZARD_STAT_EN adds a 32-bit wrapping count of stalled cycles.
module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  // Four bits covers the longer of the two unit latencies.
  localparam logic [3:0] MULT_N = 4'(MULT_CYC);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYC);

  logic [3:0] md_cnt;
  logic       hit_e_rs, hit_m_rs, hit_e_rt, hit_m_rt;
  logic       stall_rs, stall_rt, md_busy, md_stall, stall;
  logic [1:0] fwd_rs, fwd_rt;

  // A pending write matches only a nonzero register; $0 is hardwired.
  function automatic logic hit(input logic we, input logic [4:0] a3, input logic [4:0] x);
    return we && (a3 == x) && (x != 5'd0);
  endfunction

  // Operand match, stall decision and forwarding select, all from current inputs.
  always_comb begin
    hit_e_rs = hit(hz.RegWriteE, hz.A3E, hz.rsD);
    hit_m_rs = hit(hz.RegWriteM, hz.A3M, hz.rsD);
    hit_e_rt = hit(hz.RegWriteE, hz.A3E, hz.rtD);
    hit_m_rt = hit(hz.RegWriteM, hz.A3M, hz.rtD);

    // Stall when the operand is needed before the producer can deliver it.
    // Tuse 2'b11 can never be below a Tnew of at most 2.
    stall_rs = (hit_e_rs && (hz.TuseRsD < hz.TnewE)) ||
               (hit_m_rs && (hz.TuseRsD < hz.TnewM));
    stall_rt = (hit_e_rt && (hz.TuseRtD < hz.TnewE)) ||
               (hit_m_rt && (hz.TuseRtD < hz.TnewM));

    // A start in E counts as busy this very cycle, before the counter loads.
    md_busy  = hz.mdStartE || (md_cnt != 4'd0);
    md_stall = hz.mdUseD && md_busy;
    stall    = stall_rs || stall_rt || md_stall;

    // E is the younger producer, so it wins over M.
    fwd_rs = 2'd0;
    if (hit_e_rs && (hz.TnewE == 2'd0))      fwd_rs = 2'd1;
    else if (hit_m_rs && (hz.TnewM == 2'd0)) fwd_rs = 2'd2;

    fwd_rt = 2'd0;
    if (hit_e_rt && (hz.TnewE == 2'd0))      fwd_rt = 2'd1;
    else if (hit_m_rt && (hz.TnewM == 2'd0)) fwd_rt = 2'd2;
  end

  assign hz.stallPC = stall;
  assign hz.stallFD = stall;
  assign hz.clrDE   = stall;
  assign hz.fwdRsD  = fwd_rs;
  assign hz.fwdRtD  = fwd_rt;
  assign hz.mdBusy  = md_busy;

  // Mult/div busy countdown: a start (re)loads, otherwise count down to zero and hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt <= 4'd0;
    end else if (hz.mdStartE) begin
      md_cnt <= hz.mdTypeE ? DIV_N : MULT_N;
    end else if (md_cnt != 4'd0) begin
      md_cnt <= md_cnt - 4'd1;
    end
  end

`ifdef HAZARD_STAT_EN
  logic [31:0] stall_count;

  // Stalled-cycle statistics; wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= 32'd0;
    end else if (stall) begin
      stall_count <= stall_count + 32'd1;
    end
  end

  assign hz.stallCount = stall_count;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vectors plus a per-cycle reference model.
// Model tracks the mult/div busy window as an absolute end cycle, not a countdown.
// Outputs are compared on the falling edge; inputs change 1 time unit after the rising edge.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if hz ();

  hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  int checks = 0;
  int passed = 0;
  bit run_cmp = 1'b0;

  // Reference model state
  bit          md_valid = 1'b0;
  int          md_end   = 0;
  int          cyc      = 0;
  int unsigned m_count  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic bit m_hit(input logic we, input logic [4:0] a3, input logic [4:0] x);
    return (we === 1'b1) && (a3 == x) && (x != 0);
  endfunction

  function automatic bit m_busy();
    return (hz.mdStartE === 1'b1) || (md_valid && (cyc <= md_end));
  endfunction

  function automatic bit m_stall();
    bit s;
    s = 0;
    if (m_hit(hz.RegWriteE, hz.A3E, hz.rsD) && int'(hz.TuseRsD) < int'(hz.TnewE)) s = 1;
    if (m_hit(hz.RegWriteM, hz.A3M, hz.rsD) && int'(hz.TuseRsD) < int'(hz.TnewM)) s = 1;
    if (m_hit(hz.RegWriteE, hz.A3E, hz.rtD) && int'(hz.TuseRtD) < int'(hz.TnewE)) s = 1;
    if (m_hit(hz.RegWriteM, hz.A3M, hz.rtD) && int'(hz.TuseRtD) < int'(hz.TnewM)) s = 1;
    if (hz.mdUseD === 1'b1 && m_busy()) s = 1;
    return s;
  endfunction

  function automatic int m_fwd(input logic [4:0] x);
    if (m_hit(hz.RegWriteE, hz.A3E, x) && hz.TnewE == 0) return 1;
    if (m_hit(hz.RegWriteM, hz.A3M, x) && hz.TnewM == 0) return 2;
    return 0;
  endfunction

  // Model update on each clock edge; reset wipes the busy window and the counter.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_valid = 1'b0;
      m_count  = 0;
    end else begin
      if (m_stall()) m_count++;
      if (hz.mdStartE === 1'b1) begin
        md_valid = 1'b1;
        md_end   = cyc + (hz.mdTypeE ? 10 : 5);
      end
      cyc++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (run_cmp) begin
      bit s;
      s = m_stall();
      chk("cmp_stallPC", 32'(hz.stallPC), 32'(s));
      chk("cmp_stallFD", 32'(hz.stallFD), 32'(s));
      chk("cmp_clrDE",   32'(hz.clrDE),   32'(s));
      chk("cmp_mdBusy",  32'(hz.mdBusy),  32'(m_busy()));
      if (!s) begin
        chk("cmp_fwdRsD", 32'(hz.fwdRsD), 32'(m_fwd(hz.rsD)));
        chk("cmp_fwdRtD", 32'(hz.fwdRtD), 32'(m_fwd(hz.rtD)));
      end
`ifdef HAZARD_STAT_EN
      chk("cmp_stallCount", hz.stallCount, m_count);
`endif
    end
  end

  task automatic idle();
    hz.rsD = 0; hz.rtD = 0; hz.TuseRsD = 0; hz.TuseRtD = 0;
    hz.RegWriteE = 0; hz.A3E = 0; hz.TnewE = 0;
    hz.RegWriteM = 0; hz.A3M = 0; hz.TnewM = 0;
    hz.mdStartE = 0; hz.mdTypeE = 0; hz.mdUseD = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use();
    idle();
    hz.rsD = 5; hz.TuseRsD = 0; hz.TuseRtD = 3;
    hz.RegWriteE = 1; hz.A3E = 5; hz.TnewE = 1;
  endtask

  // Starts a mult/div in the current cycle and counts cycles where the watched output is high.
  task automatic md_run(input bit is_div, input bit use_d, input bit watch_stall, output int n);
    n = 0;
    idle();
    hz.mdStartE = 1; hz.mdTypeE = is_div; hz.mdUseD = use_d;
    for (int i = 0; i < 40; i++) begin
      #1;
      if ((watch_stall ? hz.stallPC : hz.mdBusy) !== 1'b1) break;
      n++;
      step();
      hz.mdStartE = 0;
    end
  endtask

  initial begin
    int n;
    idle();
    reset = 1'b0;
    #2;
    chk("rst_stallPC", 32'(hz.stallPC), 0);
    chk("rst_clrDE",   32'(hz.clrDE),   0);
    chk("rst_mdBusy",  32'(hz.mdBusy),  0);
    chk("rst_fwdRsD",  32'(hz.fwdRsD),  0);
`ifdef HAZARD_STAT_EN
    chk("rst_stallCount", hz.stallCount, 0);
`endif
    step();
    reset = 1'b1;
    run_cmp = 1'b1;

    // Load-use: E producer not ready yet
    step(); load_use(); #1;
    chk("lu_stall", 32'(hz.stallPC), 1);
    chk("lu_clrDE", 32'(hz.clrDE), 1);
    // Next cycle: producer now in M with result ready
    step(); hz.RegWriteE = 0; hz.A3E = 0; hz.TnewE = 0;
    hz.RegWriteM = 1; hz.A3M = 5; hz.TnewM = 0; #1;
    chk("lu2_stall", 32'(hz.stallPC), 0);
    chk("lu2_fwdRsD", 32'(hz.fwdRsD), 2);

    // E over M priority
    step(); idle(); hz.TuseRsD = 3;
    hz.rtD = 8; hz.TuseRtD = 1;
    hz.RegWriteE = 1; hz.A3E = 8; hz.TnewE = 0;
    hz.RegWriteM = 1; hz.A3M = 8; hz.TnewM = 0; #1;
    chk("prio_fwdRtD", 32'(hz.fwdRtD), 1);
    chk("prio_stall", 32'(hz.stallPC), 0);

    // M producer not ready, rt needed now
    step(); idle(); hz.rtD = 9; hz.TuseRtD = 0; hz.TuseRsD = 3;
    hz.RegWriteM = 1; hz.A3M = 9; hz.TnewM = 1; #1;
    chk("m_stall", 32'(hz.stallFD), 1);

    // Register $0 never matches
    step(); idle(); hz.rsD = 0; hz.TuseRsD = 0; hz.TuseRtD = 3;
    hz.RegWriteE = 1; hz.A3E = 0; hz.TnewE = 2; #1;
    chk("r0_stall", 32'(hz.stallPC), 0);
    chk("r0_fwdRsD", 32'(hz.fwdRsD), 0);

    // Unused operand never stalls
    step(); idle(); hz.rsD = 5; hz.TuseRsD = 3; hz.TuseRtD = 3;
    hz.RegWriteE = 1; hz.A3E = 5; hz.TnewE = 2; #1;
    chk("tuse3_stall", 32'(hz.stallPC), 0);

    // Divide and multiply stall windows
    step(); md_run(1'b1, 1'b1, 1'b1, n);
    chk("div_stall_cycles", n, 11);
    idle(); step(); md_run(1'b0, 1'b1, 1'b1, n);
    chk("mult_stall_cycles", n, 6);

    // Reset three cycles into a divide
    idle(); step(); hz.mdStartE = 1; hz.mdTypeE = 1;
    step(); hz.mdStartE = 0;
    step(); step();
    chk("pre_rst_busy", 32'(hz.mdBusy), 1);
    reset = 1'b0; #1;
    chk("mid_rst_busy", 32'(hz.mdBusy), 0);
`ifdef HAZARD_STAT_EN
    chk("mid_rst_count", hz.stallCount, 0);
`endif
    step(); reset = 1'b1;
    step(); md_run(1'b0, 1'b0, 1'b0, n);
    chk("post_rst_mult_busy", n, 6);

`ifdef HAZARD_STAT_EN
    // Four load-use stalls plus one divide stall
    idle(); step(); reset = 1'b0; step(); reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(); load_use();
      step(); idle();
    end
    step(); md_run(1'b1, 1'b1, 1'b1, n);
    chk("stat_count", hz.stallCount, 15);
`endif

    idle(); step(); step();
    run_cmp = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected finish");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and stall controller for the five-stage MIPS pipeline. It sits at the D stage and compares the operand needs of the instruction in D with the pending writes in E and M. From that comparison it drives the PC/F-D hold, the D/E register `clr` (bubble insert) and the D-stage forwarding selects. It also owns the multiply/divide busy counter, which stalls HI/LO-dependent instructions until the unit finishes.

## Interface
Parameters:
- `MULT_CYC`, 5: busy cycles after a `mult`/`multu` leaves E.
- `DIV_CYC`, 10: busy cycles after a `div`/`divu` leaves E.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `rsD`, `rtD`  in  5 each  source register numbers of the instruction in D.
- `TuseRsD`, `TuseRtD`  in  2 each  cycles until D needs rs/rt; 2'b11 means the operand is unused.
- `RegWriteE`  in  1  E instruction writes the register file.
- `A3E`  in  5  E destination register.
- `TnewE`  in  2  cycles until the E result exists; already decremented by the D/E register.
- `RegWriteM`, `A3M`, `TnewM`  in  1/5/2  same meaning for the M stage.
- `mdStartE`  in  1  mult/div instruction is in E this cycle.
- `mdTypeE`  in  1  0 = mult, 1 = div.
- `mdUseD`  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- `stallPC`  out  1  hold PC.
- `stallFD`  out  1  hold F/D register.
- `clrDE`  out  1  drives D/E `clr`.
- `fwdRsD`, `fwdRtD`  out  2 each  0 = register file, 1 = E result, 2 = M result.
- `mdBusy`  out  1  mult/div unit busy.
- `stallCount`  out  32  stall-cycle counter; present only with `HAZARD_STAT_EN`.

## Operation
- Match rules:
  - `hitE(x)` = `RegWriteE` & (`A3E`==x) & (x!=0).
  - `hitM(x)` is the same rule applied to the M-stage inputs.
- Data stall:
  - `stallRs` = (hitE(rsD) & TuseRsD<TnewE) | (hitM(rsD) & TuseRsD<TnewM).
  - `stallRt` uses the same rule with rtD and TuseRtD.
- Mult/div counter `mdCnt`:
  - Width is 4 bits, sized for the larger of `MULT_CYC` and `DIV_CYC`.
  - On a clock edge with `mdStartE`=1, `mdCnt` loads `MULT_CYC` or `DIV_CYC` according to `mdTypeE`. A new start while already busy reloads the counter (restarts it).
  - Otherwise, if `mdCnt`!=0, it decrements by 1. It never wraps below 0.
- `mdBusy` = `mdStartE` | (`mdCnt`!=0).
- `mdStall` = `mdUseD` & `mdBusy`.
- `stall` = `stallRs` | `stallRt` | `mdStall`. `stallPC` = `stallFD` = `clrDE` = `stall`.
- Forwarding, with E taking priority over M:
  - fwdRsD=1 if hitE(rsD) & TnewE==0.
  - Else fwdRsD=2 if hitM(rsD) & TnewM==0.
  - Else fwdRsD=0.
  - fwdRtD follows the same rules with rtD.
- When `stall`=1 the forwarding selects are don't-care.

## Timing
- `stallRs`, `stallRt`, the forwarding selects and `stall` are combinational, with zero latency: they are valid in the same cycle as their inputs.
- Only `mdCnt` and `stallCount` are registered.
- Reset (`reset`=0, asynchronous):
  - `mdCnt`=0 and `stallCount`=0 immediately.
  - With all inputs at 0, every output is 0.
  - Reset asserted mid-multiply or mid-divide aborts the count; `mdBusy` falls as soon as `mdStartE`=0.
- A start in cycle t gives `mdBusy`=1 for cycles t … t+N, where N = `MULT_CYC` or `DIV_CYC`, and `mdBusy`=0 from cycle t+N+1.
- `mdStartE` and a D-stage HI/LO instruction in the same cycle: the stall holds that cycle.
- `x`==0 never matches, so $0 causes no stall and no forwarding.
- Tuse 2'b11 never stalls, because Tnew ≤ 2.

## Configuration
- `HAZARD_STAT_EN` defined:
  - `stallCount` port exists.
  - It increments by 1 on every rising edge where `stall`=1.
  - It wraps from 32'hFFFFFFFF to 0 and resets to 0.
- `HAZARD_STAT_EN` not defined: the port and the counter are absent, and all other behaviour is identical.

## Test plan
- Load-use stall: `rsD`=5, `TuseRsD`=0, `RegWriteE`=1, `A3E`=5, `TnewE`=1 -> `stall`=1 and `clrDE`=1. The next cycle, with `A3M`=5, `TnewM`=0 and E cleared -> `stall`=0, `fwdRsD`=2.
- Forward priority: `rtD`=8, `TuseRtD`=1, E and M both write 8 with Tnew=0 -> `fwdRtD`=1, `stall`=0.
- Register 0: `rsD`=0, `A3E`=0, `RegWriteE`=1, `TnewE`=2, `TuseRsD`=0 -> `stall`=0, `fwdRsD`=0.
- Divide: `mdStartE`=1 with `mdTypeE`=1 for one cycle, then `mdUseD`=1 held -> `stall`=1 for exactly 11 cycles (start cycle plus 10), then 0. With `MULT_CYC`=5 a multiply gives 6 cycles.
- Reset mid-divide: pull `reset` low 3 cycles after the start -> `mdBusy`=0 immediately and `stallCount`=0. Multiply after release -> normal 6-cycle busy.
- With `HAZARD_STAT_EN`: 4 load-use stalls plus one 11-cycle divide stall -> `stallCount`=15.
